// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Handles load-use hazards, EX-resolved taken branches, data-memory waits
// with a timeout, and the halt drain sequence.
// Optional build macro PIPE_PERF_CNT_EN adds saturating stall/flush
// cycle counters (stall_cnt, flush_cnt).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; hazards/branches/halt evaluated by priority
// MEM_WAIT | data memory busy; whole pipe frozen, timeout counting
// DRAIN    | halt seen in EX; front end flushed while older ops retire
// HALTED   | pipeline drained; everything held until reset
module pipe_hazard_ctrl #(
  parameter int HALT_DRAIN  = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] src0_addr_ID,
  input  logic [3:0] src1_addr_ID,
  input  logic       src0_use_ID,
  input  logic       src1_use_ID,
  input  logic       re_mem_EX,
  input  logic [3:0] dst_addr_EX,
  input  logic       br_taken_EX,
  input  logic       hlt_EX,
  input  logic       mem_busy,
  output logic       stall_pc,
  output logic       stall_IF_ID,
  output logic       stall_ID_EX,
  output logic       stall_EX_MEM,
  output logic       flush_IF_ID,
  output logic       flush_ID_EX,
  output logic       halted,
  output logic       mem_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] DRAIN_C   = CNT_W'(HALT_DRAIN);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic             load_use;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign load_use = re_mem_EX && (dst_addr_EX != 4'd0) &&
                    ((src0_use_ID && (src0_addr_ID == dst_addr_EX)) ||
                     (src1_use_ID && (src1_addr_ID == dst_addr_EX)));

  assign cnt_inc = cnt + ONE_C;
  assign cnt_sat = (cnt >= TIMEOUT_C) ? TIMEOUT_C : cnt_inc;

  // Per-stage stall/flush controls, combinational so they act on this edge.
  always_comb begin
    stall_pc     = 1'b0;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    case (state)
      RUN: begin
        if (mem_busy) begin
          stall_pc     = 1'b1;
          stall_IF_ID  = 1'b1;
          stall_ID_EX  = 1'b1;
          stall_EX_MEM = 1'b1;
        end else if (hlt_EX) begin
          stall_pc    = 1'b1;
          flush_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
        end else if (br_taken_EX) begin
          flush_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
        end
      end
      MEM_WAIT: begin
        stall_pc     = mem_busy;
        stall_IF_ID  = mem_busy;
        stall_ID_EX  = mem_busy;
        stall_EX_MEM = mem_busy;
      end
      DRAIN: begin
        stall_pc     = 1'b1;
        flush_IF_ID  = 1'b1;
        flush_ID_EX  = 1'b1;
        stall_EX_MEM = mem_busy;
      end
      HALTED: begin
        stall_pc     = 1'b1;
        stall_IF_ID  = 1'b1;
        stall_ID_EX  = 1'b1;
        stall_EX_MEM = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencing FSM with shared timeout/drain counter and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      halted  <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            state <= MEM_WAIT;
            cnt   <= ONE_C;
            if (MEM_TIMEOUT <= 1) mem_err <= 1'b1;
          end else if (hlt_EX) begin
            cnt <= ONE_C;
            if (HALT_DRAIN <= 1) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_busy) begin
            cnt <= cnt_sat;
            if (cnt_sat == TIMEOUT_C) mem_err <= 1'b1;
          end else begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        DRAIN: begin
          // A busy memory freezes EX/MEM, so the drain clock pauses with it.
          if (!mem_busy) begin
            cnt <= cnt_inc;
            if (cnt_inc >= DRAIN_C) begin
              state  <= HALTED;
              halted <= 1'b1;
            end
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating counts of PC-stall cycles and ID/EX-flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_pc && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush_ID_EX && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
